// File: rtl/clocked_stream_driver.sv
// clocked_stream_driver
// Bench-side stimulus driver. Words pushed by the testbench are buffered in a
// DEPTH-entry FIFO and replayed onto a valid/ready stream toward the DUT.
// An optional idle gap can follow each beat. Handshake pulses, a drain pulse
// and a running beat counter are reported back to the testbench.
// Optional feature: define CLOCKED_STREAM_DRIVER_STALL_CNT_EN to add o_stall,
// a wrapping count of cycles spent with o_valid high and i_ready low.
module clocked_stream_driver #(
   parameter int BW    = 8,
   parameter int DEPTH = 16,
   parameter int GW    = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [BW-1:0]            i_push_data,
   input  logic [GW-1:0]            i_gap,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   output logic                     o_valid,
   output logic [BW-1:0]            o_data,
   input  logic                     i_ready,
   output logic                     o_beat,
   output logic                     o_drained,
   output logic [31:0]              o_beats
`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
   ,
   output logic [31:0]              o_stall
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t          state_reg, state_next;

   logic [BW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW-1:0]   rd_ptr_next;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   count_after_pop;
   logic [CW-1:0]   count_next;
   logic            full_reg;
   logic            overflow_reg;

   logic [BW-1:0]   data_reg;
   logic [BW-1:0]   data_next;
   logic            load_data;

   logic [GW-1:0]   gap_reg, gap_next;

   logic            beat_reg;
   logic            drained_reg;
   logic [31:0]     beats_reg;

   logic            push_acc;
   logic            handshake;

   // Acceptance uses the registered full flag, so a push in the same cycle
   // as a pop from a full FIFO is still rejected.
   assign push_acc        = i_push && !full_reg;
   assign handshake       = (state_reg == ST_DRIVE) && i_ready;
   assign count_after_pop = count_reg - CW'(handshake);
   assign count_next      = count_after_pop + CW'(push_acc);
   assign rd_ptr_next     = handshake ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

   // Next-state and gap-counter logic for the stream FSM.
   always_comb begin
      state_next = state_reg;
      gap_next   = gap_reg;
      case (state_reg)
         ST_IDLE: begin
            if (count_reg != '0) begin
               state_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (handshake) begin
               if (i_gap != '0) begin
                  state_next = ST_GAP;
                  gap_next   = i_gap;
               end else if (count_next == '0) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            // A push landing in the last gap cycle counts, so the stream
            // resumes without an extra idle cycle.
            if (gap_reg <= GW'(1)) begin
               state_next = (count_next != '0) ? ST_DRIVE : ST_IDLE;
            end else begin
               gap_next = gap_reg - GW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output word selection: reload whenever a new beat is presented. When
   // the head entry is being written in this very cycle (FIFO would be empty
   // after the pop), forward the incoming word instead of the stale array.
   always_comb begin
      load_data = (state_next == ST_DRIVE) &&
                  ((state_reg != ST_DRIVE) || handshake);
      if (push_acc && (count_after_pop == '0)) begin
         data_next = i_push_data;
      end else begin
         data_next = mem[rd_ptr_next];
      end
   end

   // FIFO storage write port; contents need no reset since pointers do.
   always_ff @(posedge i_clk) begin
      if (push_acc) begin
         mem[wr_ptr_reg] <= i_push_data;
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         full_reg     <= (count_next == CW'(DEPTH));
         overflow_reg <= overflow_reg | (i_push && full_reg);
      end
   end

   // FSM state, gap counter and the registered stream word.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_reg <= ST_IDLE;
         gap_reg   <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         gap_reg   <= gap_next;
         if (load_data) begin
            data_reg <= data_next;
         end
      end
   end

   // Handshake reporting: beat pulse, drain pulse and wrapping beat count.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         beat_reg    <= 1'b0;
         drained_reg <= 1'b0;
         beats_reg   <= '0;
      end else begin
         beat_reg    <= handshake;
         drained_reg <= handshake && (count_next == '0);
         beats_reg   <= beats_reg + 32'(handshake);
      end
   end

`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
   logic [31:0] stall_reg;

   // Count cycles where a beat is offered but the DUT holds off.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         stall_reg <= '0;
      end else begin
         stall_reg <= stall_reg + 32'((state_reg == ST_DRIVE) && !i_ready);
      end
   end

   assign o_stall = stall_reg;
`endif

   assign o_full     = full_reg;
   assign o_count    = count_reg;
   assign o_overflow = overflow_reg;
   assign o_valid    = (state_reg == ST_DRIVE);
   assign o_data     = data_reg;
   assign o_beat     = beat_reg;
   assign o_drained  = drained_reg;
   assign o_beats    = beats_reg;

endmodule

// File: tb/tb_clocked_stream_driver.sv
// Testbench for clocked_stream_driver: directed scenarios followed by a
// randomized phase. A negedge monitor keeps a queue of words the FIFO should
// hold and checks every handshake and status output against it.
`timescale 1ns/1ps
module tb_clocked_stream_driver;

   localparam int BW    = 8;
   localparam int DEPTH = 16;
   localparam int GW    = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            push = 1'b0;
   logic [BW-1:0]   push_data = '0;
   logic [GW-1:0]   gap = '0;
   logic            ready = 1'b0;

   logic            o_full;
   logic [CW-1:0]   o_count;
   logic            o_overflow;
   logic            o_valid;
   logic [BW-1:0]   o_data;
   logic            o_beat;
   logic            o_drained;
   logic [31:0]     o_beats;
`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
   logic [31:0]     o_stall;
`endif

   always #5 clk = ~clk;

   clocked_stream_driver #(.BW(BW), .DEPTH(DEPTH), .GW(GW)) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_push      (push),
      .i_push_data (push_data),
      .i_gap       (gap),
      .o_full      (o_full),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .i_ready     (ready),
      .o_beat      (o_beat),
      .o_drained   (o_drained),
      .o_beats     (o_beats)
`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
      ,
      .o_stall     (o_stall)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model state: FIFO contents as a queue plus report registers.
   logic [BW-1:0] exp_q[$];
   int            beats_m     = 0;
   int            stall_m     = 0;
   bit            ovf_m       = 1'b0;
   bit            prev_hs     = 1'b0;
   bit            prev_drain  = 1'b0;
   bit            prev_stall  = 1'b0;
   logic [BW-1:0] prev_data   = '0;
   int            gap_hold    = 0;
   bit            cont_due    = 1'b0;
   bit            mon_en      = 1'b0;
   bit            mon_hs;
   bit            mon_pok;
   int            drained_seen = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("count",    32'(o_count),    32'(exp_q.size()));
         check("full",     32'(o_full),     32'(exp_q.size() == DEPTH));
         check("overflow", 32'(o_overflow), 32'(ovf_m));
         check("beat",     32'(o_beat),     32'(prev_hs));
         check("drained",  32'(o_drained),  32'(prev_drain));
         check("beats",    o_beats,         32'(beats_m));
`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
         check("stall",    o_stall,         32'(stall_m));
`endif
         if (prev_stall) begin
            check("hold_valid", 32'(o_valid), 1);
            check("hold_data",  32'(o_data),  32'(prev_data));
         end
         if (cont_due) begin
            cont_due = 1'b0;
            check("continuity", 32'(o_valid), 32'(exp_q.size() != 0));
         end else if (gap_hold != 0) begin
            check("gap_idle", 32'(o_valid), 0);
            gap_hold--;
            if (gap_hold == 0) cont_due = 1'b1;
         end
         if (o_drained) drained_seen++;

         if (!rst_n) begin
            exp_q.delete();
            beats_m = 0; stall_m = 0; ovf_m = 1'b0;
            prev_hs = 1'b0; prev_drain = 1'b0; prev_stall = 1'b0;
            prev_data = '0; gap_hold = 0; cont_due = 1'b0;
         end else begin
            mon_hs  = o_valid && ready;
            mon_pok = push && (exp_q.size() < DEPTH);
            if (push && !mon_pok) ovf_m = 1'b1;
            if (mon_hs) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL stray_beat: got data 0x%0h, want no beat (queue empty) at %0t", o_data, $time);
               end else begin
                  check("beat_data", 32'(o_data), 32'(exp_q.pop_front()));
               end
               beats_m++;
               if (gap == '0) cont_due = 1'b1;
               else gap_hold = int'(gap);
            end
            if (mon_pok) exp_q.push_back(push_data);
            prev_drain = mon_hs && (exp_q.size() == 0);
            prev_hs    = mon_hs;
            prev_stall = o_valid && !ready;
            prev_data  = o_data;
            if (prev_stall) stall_m++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick;
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int zeros;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick;
      rst_n = 1'b1;
      check("rst_valid",   32'(o_valid),    0);
      check("rst_data",    32'(o_data),     0);
      check("rst_count",   32'(o_count),    0);
      check("rst_full",    32'(o_full),     0);
      check("rst_ovf",     32'(o_overflow), 0);
      check("rst_beat",    32'(o_beat),     0);
      check("rst_drained", 32'(o_drained),  0);
      check("rst_beats",   o_beats,         0);
      mon_en = 1'b1;
      tick;

      // Back-to-back stream
      ready = 1'b1; gap = '0;
      push = 1'b1; push_data = 8'h11; tick;
      check("b2b_lat_idle", 32'(o_valid), 0);
      push_data = 8'h22; tick;
      check("b2b_v1", 32'(o_valid), 1); check("b2b_d1", 32'(o_data), 32'h11);
      push_data = 8'h33; tick;
      check("b2b_v2", 32'(o_valid), 1); check("b2b_d2", 32'(o_data), 32'h22);
      push = 1'b0; tick;
      check("b2b_v3", 32'(o_valid), 1); check("b2b_d3", 32'(o_data), 32'h33);
      tick;
      check("b2b_end_valid", 32'(o_valid), 0);
      check("b2b_drained", 32'(o_drained), 1);
      check("b2b_beats", o_beats, 3);
      tick;
      check("b2b_drain_once", 32'(drained_seen), 1);

      // Backpressure
      ready = 1'b0;
      push = 1'b1; push_data = 8'hA5; tick;
      push = 1'b0; tick;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(o_valid), 1);
         check("bp_data",  32'(o_data),  32'hA5);
         tick;
      end
      ready = 1'b1;
      check("bp_valid_last", 32'(o_valid), 1);
      check("bp_data_last",  32'(o_data),  32'hA5);
      tick;
      check("bp_beat",  32'(o_beat),  1);
      check("bp_after", 32'(o_valid), 0);
`ifdef CLOCKED_STREAM_DRIVER_STALL_CNT_EN
      check("bp_stall", o_stall, 5);
`endif
      repeat (2) tick;

      // Gap insertion
      gap = 4'd3; ready = 1'b1;
      push = 1'b1; push_data = 8'h01; tick;
      push_data = 8'h02; tick;
      push = 1'b0;
      check("gap_first_valid", 32'(o_valid), 1);
      check("gap_first_data",  32'(o_data),  32'h01);
      tick;
      zeros = 0;
      while (!o_valid && zeros < 20) begin
         zeros++;
         tick;
      end
      check("gap_len",    32'(zeros),  3);
      check("gap_second", 32'(o_data), 32'h02);
      gap = '0;
      repeat (4) tick;

      // Full and overflow
      ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         push = 1'b1; push_data = BW'(8'h40 + i); tick;
      end
      push = 1'b0;
      check("full_flag",  32'(o_full),     1);
      check("full_count", 32'(o_count),    16);
      check("full_ovf",   32'(o_overflow), 1);
      ready = 1'b1;
      wait_empty(100);
      repeat (2) tick;
      check("full_beats", o_beats, 22);
      repeat (2) tick;

      // Push against a pop while full
      rst_n = 1'b0; tick; rst_n = 1'b1; tick;
      check("rst2_ovf", 32'(o_overflow), 0);
      ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push = 1'b1; push_data = BW'(8'h60 + i); tick;
      end
      check("pp_full", 32'(o_full), 1);
      check("pp_ovf0", 32'(o_overflow), 0);
      ready = 1'b1; push_data = 8'h7E; tick;
      check("pp_count15", 32'(o_count), 15);
      check("pp_ovf1",    32'(o_overflow), 1);
      ready = 1'b0; push_data = 8'h7F; tick;
      push = 1'b0;
      check("pp_count16", 32'(o_count), 16);
      check("pp_full2",   32'(o_full), 1);
      ready = 1'b1;
      wait_empty(100);
      repeat (3) tick;

      // Reset mid-stream
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; push_data = BW'(8'h90 + i); tick;
      end
      push = 1'b0;
      ready = 1'b1; tick; tick;
      ready = 1'b0; rst_n = 1'b0; tick;
      check("mid_rst_valid", 32'(o_valid), 0);
      check("mid_rst_count", 32'(o_count), 0);
      check("mid_rst_beats", o_beats,      0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("post_rst_idle",  32'(o_valid), 0);
         check("post_rst_count", 32'(o_count), 0);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         push      = ($urandom_range(0, 99) < 45);
         push_data = BW'($urandom);
         ready     = ($urandom_range(0, 99) < 60);
         gap       = ($urandom_range(0, 3) == 0) ? GW'($urandom_range(1, 3)) : '0;
         tick;
      end
      push = 1'b0; gap = '0; ready = 1'b1;
      wait_empty(200);
      repeat (8) tick;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
